// File: rtl/loop_deadtime_if.sv
`default_nettype none
// ============================================================================
// Module   : loop_deadtime_if
// Purpose  : Bundles the control and status signals between the loop PWM
//            modulator and the break-before-make sequencer.
// Ports    : en, pwm, fault, dt_hl, dt_lh      (modulator -> sequencer)
//            top_on, bot_on, fault_lat, state_o (sequencer -> drivers/monitor)
// Revision : 1.0 - initial release
// ============================================================================
interface loop_deadtime_if #(
    parameter int CNT_W = 6
);
    logic             en;
    logic             pwm;
    logic             fault;
    logic [CNT_W-1:0] dt_hl;
    logic [CNT_W-1:0] dt_lh;
    logic             top_on;
    logic             bot_on;
    logic             fault_lat;
    logic [2:0]       state_o;

    modport master (
        output en, pwm, fault, dt_hl, dt_lh,
        input  top_on, bot_on, fault_lat, state_o
    );

    modport slave (
        input  en, pwm, fault, dt_hl, dt_lh,
        output top_on, bot_on, fault_lat, state_o
    );
endinterface
`default_nettype wire

// File: rtl/loop_deadtime_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : loop_deadtime_ctrl
// Purpose  : Break-before-make sequencer for the step-down loop gate drivers.
//            Turns one PWM request into non-overlapping top/bottom commands
//            with programmable dead time each way, a minimum top on-time and
//            a latched fault state.
// Ports    : CELCLK   - clock, rising edge
//            CELRSTN  - asynchronous active-low reset
//            CELV, CELG, SUB - supply/ground/substrate pins, no logic use
//            bus      - loop_deadtime_if.slave (en, pwm, fault, dt_hl, dt_lh
//                       in; top_on, bot_on, fault_lat, state_o out)
// Revision : 1.0 - initial release
// ============================================================================
module loop_deadtime_ctrl #(
    parameter int CNT_W  = 6,
    parameter int MIN_ON = 4
) (
    input  wire logic      CELCLK,
    input  wire logic      CELRSTN,
    input  wire logic      CELV,
    input  wire logic      CELG,
    input  wire logic      SUB,
    loop_deadtime_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BOT   = 3'd1,
        ST_DT_HL = 3'd2,
        ST_TOP   = 3'd3,
        ST_DT_LH = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_MIN_ON = CNT_W'(MIN_ON);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             top_on_q, bot_on_q, fault_lat_q;
    logic             cnt_done;

    // Power pins carry no logic; fold them into one sink.
    logic w_unused_pins;
    assign w_unused_pins = CELV ^ CELG ^ SUB;

    // A zero dead time still yields a one-cycle both-off gap.
    function automatic logic [CNT_W-1:0] clamp1(input logic [CNT_W-1:0] v);
        return (v == '0) ? c_ONE : v;
    endfunction

    // The counter holds the number of cycles still to spend in the current
    // timed state, including the present one; it parks at 1 and never wraps.
    assign cnt_done = (cnt_q <= c_ONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.fault && (state_q != ST_FAULT)) begin
            state_d = ST_FAULT;
        end else if (!bus.en && (state_q inside {ST_BOT, ST_DT_HL, ST_TOP, ST_DT_LH})) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Start-up always passes through DT_LH so the bottom
                    // switch honours dt_lh even after an abrupt disable.
                    if (bus.en) begin
                        state_d = ST_DT_LH;
                        cnt_d   = clamp1(bus.dt_lh);
                    end
                end
                ST_BOT: begin
                    if (bus.pwm) begin
                        state_d = ST_DT_HL;
                        cnt_d   = clamp1(bus.dt_hl);
                    end
                end
                ST_DT_HL: begin
                    // Committed: pwm is ignored until TOP is reached.
                    if (cnt_done) begin
                        state_d = ST_TOP;
                        cnt_d   = c_MIN_ON;
                    end else begin
                        cnt_d = cnt_q - c_ONE;
                    end
                end
                ST_TOP: begin
                    if (!bus.pwm && cnt_done) begin
                        state_d = ST_DT_LH;
                        cnt_d   = clamp1(bus.dt_lh);
                    end else if (!cnt_done) begin
                        cnt_d = cnt_q - c_ONE;
                    end
                end
                ST_DT_LH: begin
                    if (cnt_done) begin
                        state_d = ST_BOT;
                    end else begin
                        cnt_d = cnt_q - c_ONE;
                    end
                end
                ST_FAULT: begin
                    if (!bus.fault && !bus.en) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they switch on the same
    // edge as the state register.
    always_ff @(posedge CELCLK or negedge CELRSTN) begin
        if (!CELRSTN) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            top_on_q    <= 1'b0;
            bot_on_q    <= 1'b0;
            fault_lat_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            top_on_q    <= (state_d == ST_TOP);
            bot_on_q    <= (state_d == ST_BOT);
            fault_lat_q <= (state_d == ST_FAULT);
        end
    end

    assign bus.top_on    = top_on_q;
    assign bus.bot_on    = bot_on_q;
    assign bus.fault_lat = fault_lat_q;
    assign bus.state_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_loop_deadtime_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_loop_deadtime_ctrl
// Purpose  : Self-checking bench for loop_deadtime_ctrl. A timestamp-based
//            reference model (phase + entry edge + phase length) predicts
//            state and outputs every cycle; scenario tasks add direct checks
//            of gap lengths, on-times and fault/disable/reset behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_loop_deadtime_ctrl;
    localparam int CNT_W  = 6;
    localparam int MIN_ON = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic vdd  = 1'b1;
    logic gnd  = 1'b0;
    logic sub  = 1'b0;

    loop_deadtime_if #(.CNT_W(CNT_W)) bus ();

    loop_deadtime_ctrl #(.CNT_W(CNT_W), .MIN_ON(MIN_ON)) dut (
        .CELCLK (clk),
        .CELRSTN(rstn),
        .CELV   (vdd),
        .CELG   (gnd),
        .SUB    (sub),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase (0 idle,1 bot,2 dt_hl,3 top,4 dt_lh,5 fault),
    // the edge at which it was entered, and the required length of a dead time.
    int m_state = 0;
    int m_entry = 0;
    int m_len   = 1;
    int edge_n  = 0;

    function automatic int clampdt(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function void model_edge();
        int e;
        int nxt;
        edge_n = edge_n + 1;
        e      = edge_n - m_entry;
        nxt    = m_state;
        if (bus.fault && m_state != 5) nxt = 5;
        else if (!bus.en && m_state >= 1 && m_state <= 4) nxt = 0;
        else begin
            case (m_state)
                0: if (bus.en) begin nxt = 4; m_len = clampdt(int'(bus.dt_lh)); end
                1: if (bus.pwm) begin nxt = 2; m_len = clampdt(int'(bus.dt_hl)); end
                2: if (e >= m_len) nxt = 3;
                3: if (!bus.pwm && e >= MIN_ON) begin nxt = 4; m_len = clampdt(int'(bus.dt_lh)); end
                4: if (e >= m_len) nxt = 1;
                5: if (!bus.fault && !bus.en) nxt = 0;
                default: nxt = 0;
            endcase
        end
        if (nxt != m_state) begin
            m_state = nxt;
            m_entry = edge_n;
        end
    endfunction

    function logic [5:0] exp_vec();
        return {3'(m_state), (m_state == 3), (m_state == 1), (m_state == 5)};
    endfunction

    function logic [5:0] obs_vec();
        return {bus.state_o, bus.top_on, bus.bot_on, bus.fault_lat};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rstn) model_edge();
        else m_state = 0;
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.en = 0; bus.pwm = 0; bus.fault = 0; bus.dt_hl = '0; bus.dt_lh = '0;
        tick(); tick();
        n_vec++;
        if (obs_vec() !== 6'b000000) begin
            n_err++; $display("FAIL reset_state act=%b exp=%b", obs_vec(), 6'b000000);
        end
        rstn = 1'b1;
        tick();
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_err++; $display("FAIL reset_release act=%b exp=%b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_enable();
        int exp_s[3] = '{4, 4, 1};
        bus.dt_lh = 6'd2; bus.pwm = 0; bus.en = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (bus.state_o !== 3'(exp_s[i]) || obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL enable_seq[%0d] act=%b exp_state=%0d model=%b", i, obs_vec(), exp_s[i], exp_vec());
            end
        end
    endtask

    // Drive a pwm square wave and measure each both-off gap preceding a rise.
    task automatic run_gaps(input string nm, input int half, input int ncyc, input int g_hl, input int g_lh);
        int off_run = 0;
        int rises   = 0;
        logic pt, pb;
        pt = bus.top_on; pb = bus.bot_on;
        for (int c = 0; c < ncyc; c++) begin
            bus.pwm = ((c / half) % 2 == 0);
            tick();
            n_vec++;
            if (obs_vec() !== exp_vec() || (bus.top_on && bus.bot_on)) begin
                n_err++; $display("FAIL %s_model c=%0d act=%b exp=%b", nm, c, obs_vec(), exp_vec());
            end
            if (bus.top_on && !pt) begin
                rises++; n_vec++;
                if (off_run !== g_hl) begin
                    n_err++; $display("FAIL %s_gap_hl act=%0d exp=%0d", nm, off_run, g_hl);
                end
            end
            if (bus.bot_on && !pb) begin
                rises++; n_vec++;
                if (off_run !== g_lh) begin
                    n_err++; $display("FAIL %s_gap_lh act=%0d exp=%0d", nm, off_run, g_lh);
                end
            end
            off_run = (!bus.top_on && !bus.bot_on) ? off_run + 1 : 0;
            pt = bus.top_on; pb = bus.bot_on;
        end
        n_vec++;
        if (rises < 4) begin
            n_err++; $display("FAIL %s_rises act=%0d exp>=4", nm, rises);
        end
    endtask

    task automatic test_square();
        bus.dt_hl = 6'd3; bus.dt_lh = 6'd5;
        run_gaps("square", 20, 120, 3, 5);
    endtask

    task automatic test_min_on();
        int hi = 0;
        bus.dt_hl = 6'd1; bus.dt_lh = 6'd2;
        bus.pwm = 1;
        tick();
        bus.pwm = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL min_on_model i=%0d act=%b exp=%b", i, obs_vec(), exp_vec());
            end
            if (bus.top_on) hi++;
        end
        n_vec++;
        if (hi !== MIN_ON || bus.state_o !== 3'd1) begin
            n_err++; $display("FAIL min_on_width act=%0d/state %0d exp=%0d/state 1", hi, bus.state_o, MIN_ON);
        end
    endtask

    task automatic test_zero_dt();
        bus.dt_hl = '0; bus.dt_lh = '0;
        run_gaps("zero_dt", 8, 48, 1, 1);
    endtask

    task automatic goto_top(input string nm);
        int guard = 0;
        bus.pwm = 1;
        while (m_state != 3 && guard < 30) begin
            tick(); guard++;
        end
        n_vec++;
        if (bus.state_o !== 3'd3 || m_state != 3) begin
            n_err++; $display("FAIL %s_reach_top act=%0d exp=3", nm, bus.state_o);
        end
    endtask

    task automatic test_fault();
        goto_top("fault");
        bus.fault = 1;
        tick();
        bus.fault = 0;
        n_vec++;
        if (obs_vec() !== 6'b101001 || obs_vec() !== exp_vec()) begin
            n_err++; $display("FAIL fault_entry act=%b exp=%b", obs_vec(), 6'b101001);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (obs_vec() !== 6'b101001) begin
                n_err++; $display("FAIL fault_hold i=%0d act=%b exp=%b", i, obs_vec(), 6'b101001);
            end
        end
        bus.en = 0;
        tick();
        n_vec++;
        if (obs_vec() !== 6'b000000 || obs_vec() !== exp_vec()) begin
            n_err++; $display("FAIL fault_clear act=%b exp=%b", obs_vec(), 6'b000000);
        end
        bus.en = 1; bus.dt_lh = 6'd3;
        tick();
        n_vec++;
        if (bus.state_o !== 3'd4 || obs_vec() !== exp_vec()) begin
            n_err++; $display("FAIL fault_restart act=%0d exp=4", bus.state_o);
        end
    endtask

    task automatic test_disable();
        int dl = 0;
        goto_top("disable");
        bus.en = 0;
        tick();
        n_vec++;
        if (obs_vec() !== 6'b000000) begin
            n_err++; $display("FAIL disable_idle act=%b exp=%b", obs_vec(), 6'b000000);
        end
        bus.en = 1; bus.dt_lh = 6'd4; bus.pwm = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++; $display("FAIL disable_model i=%0d act=%b exp=%b", i, obs_vec(), exp_vec());
            end
            if (bus.state_o == 3'd4) dl++;
        end
        n_vec++;
        if (dl !== 4 || bus.bot_on !== 1'b1) begin
            n_err++; $display("FAIL disable_dt_lh act=%0d cycles bot=%b exp=4 cycles bot=1", dl, bus.bot_on);
        end
    endtask

    task automatic test_async_reset();
        goto_top("areset");
        #3;
        rstn = 1'b0;
        #1;
        n_vec++;
        if (bus.top_on !== 1'b0 || bus.state_o !== 3'd0) begin
            n_err++; $display("FAIL async_reset act=top %b state %0d exp=top 0 state 0", bus.top_on, bus.state_o);
        end
        m_state = 0;
        tick();
        rstn = 1'b1;
        bus.pwm = 0;
        tick();
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_err++; $display("FAIL async_reset_restart act=%b exp=%b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            bus.en    = ($urandom % 100) < 97;
            bus.fault = ($urandom % 100) < 2;
            if ($urandom % 12 == 0) bus.pwm = ~bus.pwm;
            if ($urandom % 30 == 0) bus.dt_hl = 6'($urandom % 8);
            if ($urandom % 30 == 0) bus.dt_lh = 6'($urandom % 8);
            tick();
            n_vec++;
            if (obs_vec() !== exp_vec() || (bus.top_on && bus.bot_on)) begin
                n_err++; $display("FAIL random c=%0d act=%b exp=%b", c, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_square();
        test_min_on();
        test_zero_dt();
        test_fault();
        test_disable();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
